// File: rtl/sample_event_arbiter.sv
// sample_event_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share one sample-capture
// register. The winning requester's data is captured into a single output
// slot and offered to one consumer under valid/ready handshaking. The slot
// can drain and refill in the same cycle, so a busy consumer sees one event
// per clock. A requester acked in the previous cycle is masked for one cycle
// so it cannot be granted twice while it lowers its request.

module sample_event_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    parameter  int CNT_W   = 16,
    localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          ack_o,
    output logic                        ev_valid_o,
    input  logic                        ev_ready_i,
    output logic [DATA_W-1:0]           ev_data_o,
    output logic [SRC_W-1:0]            ev_src_o,
    output logic [CNT_W-1:0]            ev_cnt_o,
    output logic                        busy_o
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

    slot_state_t              state_r;
    logic [NUM_REQ-1:0]       ack_r;
    logic [DATA_W-1:0]        data_r;
    logic [SRC_W-1:0]         src_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [SRC_W-1:0]         ptr_r;

    logic [NUM_REQ-1:0]       eligible_s;
    logic                     win_valid_s;
    logic [SRC_W-1:0]         win_idx_s;
    logic [SRC_W-1:0]         ptr_next_s;
    logic                     accept_s;
    logic                     cap_s;

    // Index that lies 'offset' places after 'base', wrapping modulo NUM_REQ.
    function automatic logic [SRC_W-1:0] scan_idx(
        input logic [SRC_W-1:0] base,
        input int               offset
    );
        logic [SRC_W:0] sum_v;
        sum_v = {1'b0, base} + (SRC_W+1)'(offset);
        if (sum_v >= (SRC_W+1)'(NUM_REQ)) begin
            sum_v = sum_v - (SRC_W+1)'(NUM_REQ);
        end else begin
            sum_v = sum_v;
        end
        return sum_v[SRC_W-1:0];
    endfunction

    // A requester acked last cycle is still dropping its request; ignore it.
    assign eligible_s = req_i & ~ack_r;

    // Consumer takes the held event this cycle.
    assign accept_s = (state_r == ST_FULL) && ev_ready_i;

    // The slot can take new data when empty or when it is being drained now.
    assign cap_s = (state_r == ST_EMPTY) || accept_s;

    // Round-robin search: first eligible requester at or after the pointer.
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_valid_s && eligible_s[scan_idx(ptr_r, i)]) begin
                win_valid_s = 1'b1;
                win_idx_s   = scan_idx(ptr_r, i);
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // Next search starts just past the winner so every requester gets a turn.
    assign ptr_next_s = scan_idx(win_idx_s, 1);

    // Output slot state, captured sample, ack pulse, pointer and event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            ack_r   <= '0;
            data_r  <= '0;
            src_r   <= '0;
            cnt_r   <= '0;
            ptr_r   <= '0;
        end else begin
            if (accept_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end

            if (cap_s && win_valid_s) begin
                state_r <= ST_FULL;
                data_r  <= req_data_i[win_idx_s*DATA_W +: DATA_W];
                src_r   <= win_idx_s;
                ack_r   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
                ptr_r   <= ptr_next_s;
            end else begin
                ack_r <= '0;
                ptr_r <= ptr_r;
                case (state_r)
                    ST_EMPTY: state_r <= ST_EMPTY;
                    ST_FULL:  state_r <= accept_s ? ST_EMPTY : ST_FULL;
                    default:  state_r <= ST_EMPTY;
                endcase
            end
        end
    end

    assign ev_valid_o = (state_r == ST_FULL);
    assign ev_data_o  = data_r;
    assign ev_src_o   = src_r;
    assign ev_cnt_o   = cnt_r;
    assign ack_o      = ack_r;
    assign busy_o     = ev_valid_o | (|eligible_s);

endmodule

// File: tb/tb_sample_event_arbiter.sv
// Self-checking bench for sample_event_arbiter: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a behavioural model of the slot and round-robin rules.

module tb_sample_event_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     ack_o;
    logic              ev_valid_o;
    logic              ev_ready_i;
    logic [DW-1:0]     ev_data_o;
    logic [SW-1:0]     ev_src_o;
    logic [CW-1:0]     ev_cnt_o;
    logic              busy_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sample_event_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .ack_o      (ack_o),
        .ev_valid_o (ev_valid_o),
        .ev_ready_i (ev_ready_i),
        .ev_data_o  (ev_data_o),
        .ev_src_o   (ev_src_o),
        .ev_cnt_o   (ev_cnt_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_src;
    logic [NR-1:0] m_ack;
    int            m_cnt;
    int            m_ptr;
    int            m_win;

    function automatic int pick(input logic [NR-1:0] e, input int p);
        for (int i = 0; i < NR; i++) begin
            if (e[(p + i) % NR]) return (p + i) % NR;
        end
        return -1;
    endfunction

    always_comb m_win = pick(req_i & ~m_ack, m_ptr);

    // Model: one-entry slot, round-robin grant, wrapping accept counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= 0;
            m_ack   <= '0;
            m_cnt   <= 0;
            m_ptr   <= 0;
        end else begin
            if (m_valid && ev_ready_i) m_cnt <= (m_cnt + 1) % (1 << CW);
            if ((!m_valid || ev_ready_i) && m_win >= 0) begin
                m_valid <= 1'b1;
                m_data  <= req_data_i[m_win*DW +: DW];
                m_src   <= m_win;
                m_ack   <= 4'b0001 << m_win;
                m_ptr   <= (m_win + 1) % NR;
            end else begin
                m_ack <= '0;
                if (ev_ready_i) m_valid <= 1'b0;
            end
        end
    end

    // Compare every cycle on the falling edge while out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("valid", 32'(ev_valid_o), 32'(m_valid));
            check("data",  32'(ev_data_o),  32'(m_data));
            check("src",   32'(ev_src_o),   32'(m_src));
            check("ack",   32'(ack_o),      32'(m_ack));
            check("cnt",   32'(ev_cnt_o),   32'(m_cnt));
            check("busy",  32'(busy_o),     32'(m_valid | (|(req_i & ~m_ack))));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drive_random();
        for (int k = 0; k < NR; k++) begin
            if (req_i[k] && ack_o[k]) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_data_i[k*DW +: DW] = 8'($urandom);
                end else begin
                    req_i[k] = 1'b0;
                end
            end else if (req_i[k]) begin
                if ($urandom_range(0, 19) == 0) req_i[k] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req_i[k] = 1'b1;
                req_data_i[k*DW +: DW] = 8'($urandom);
            end
        end
        ev_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int pulses;
        int acc;
        int n;
        logic saw2;

        rst_n      = 1'b0;
        req_i      = '0;
        req_data_i = '0;
        ev_ready_i = 1'b0;

        // Reset state
        #8;
        check("rst_valid", 32'(ev_valid_o), 32'd0);
        check("rst_data",  32'(ev_data_o),  32'd0);
        check("rst_src",   32'(ev_src_o),   32'd0);
        check("rst_ack",   32'(ack_o),      32'd0);
        check("rst_cnt",   32'(ev_cnt_o),   32'd0);
        #5;
        rst_n = 1'b1;
        step();

        // Single request, one-cycle latency, no second grant while masked
        req_i = 4'b0010;
        req_data_i[15:8] = 8'hA5;
        ev_ready_i = 1'b1;
        step();
        check("t1_valid", 32'(ev_valid_o), 32'd1);
        check("t1_data",  32'(ev_data_o),  32'hA5);
        check("t1_src",   32'(ev_src_o),   32'd1);
        check("t1_ack",   32'(ack_o),      32'b0010);
        step();
        check("t1_valid2", 32'(ev_valid_o), 32'd0);
        check("t1_cnt",    32'(ev_cnt_o),   32'd1);
        check("t1_ack2",   32'(ack_o),      32'd0);
        req_i = '0;
        step();

        // All requesting: strict rotation at full throughput
        pulse_reset();
        req_i = 4'b1111;
        req_data_i = {8'h13, 8'h12, 8'h11, 8'h10};
        ev_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("rr_src",  32'(ev_src_o),  32'(i % NR));
            check("rr_data", 32'(ev_data_o), 32'(8'h10 + 8'(i % NR)));
            check("rr_cnt",  32'(ev_cnt_o),  32'(i % 16));
        end
        req_i = '0;
        step();

        // Backpressure: one capture, stable data, drain+refill on ready
        pulse_reset();
        ev_ready_i = 1'b0;
        req_i = 4'b0101;
        req_data_i = {8'h00, 8'h77, 8'h00, 8'h33};
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(ev_valid_o), 32'd1);
            check("bp_src",   32'(ev_src_o),   32'd0);
            check("bp_data",  32'(ev_data_o),  32'h33);
            check("bp_ack2",  32'(ack_o[2]),   32'd0);
            if (ack_o[0]) begin
                pulses++;
                req_i[0] = 1'b0;
            end
        end
        check("bp_pulses", 32'(pulses), 32'd1);
        ev_ready_i = 1'b1;
        step();
        check("bp_src2",  32'(ev_src_o),  32'd2);
        check("bp_data2", 32'(ev_data_o), 32'h77);
        check("bp_ackr",  32'(ack_o),     32'b0100);
        check("bp_cnt",   32'(ev_cnt_o),  32'd1);
        req_i = '0;
        step();
        check("bp_empty", 32'(ev_valid_o), 32'd0);
        check("bp_cnt2",  32'(ev_cnt_o),   32'd2);

        // Counter wrap with 17 accepts
        pulse_reset();
        req_i = 4'b1111;
        ev_ready_i = 1'b1;
        acc = 0;
        n = 0;
        while (acc < 17 && n < 100) begin
            if (ev_valid_o && ev_ready_i) acc++;
            step();
            n++;
        end
        check("wrap_acc", 32'(acc), 32'd17);
        check("wrap_cnt", 32'(ev_cnt_o), 32'd1);
        req_i = '0;
        step();

        // Asynchronous reset while FULL with pointer at 3
        pulse_reset();
        req_i = 4'b0111;
        req_data_i = {8'h00, 8'hC2, 8'hC1, 8'hC0};
        ev_ready_i = 1'b1;
        step();
        step();
        step();
        check("ar_pre_valid", 32'(ev_valid_o), 32'd1);
        check("ar_pre_src",   32'(ev_src_o),   32'd2);
        ev_ready_i = 1'b0;
        req_i = '0;
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(ev_valid_o), 32'd0);
        check("ar_data",  32'(ev_data_o),  32'd0);
        check("ar_src",   32'(ev_src_o),   32'd0);
        check("ar_ack",   32'(ack_o),      32'd0);
        check("ar_cnt",   32'(ev_cnt_o),   32'd0);
        #3;
        rst_n = 1'b1;
        req_i = 4'b1001;
        req_data_i = {8'hD3, 16'h0000, 8'hD0};
        ev_ready_i = 1'b1;
        step();
        check("ar_first",  32'(ev_src_o),  32'd0);
        check("ar_fdata",  32'(ev_data_o), 32'hD0);
        step();
        check("ar_second", 32'(ev_src_o),  32'd3);
        req_i = '0;
        step();

        // Short-lived request while FULL and stalled is never granted
        pulse_reset();
        req_i = 4'b0001;
        req_data_i = {8'h00, 8'h99, 8'h00, 8'h44};
        ev_ready_i = 1'b0;
        step();
        req_i = 4'b0100;
        step();
        req_i = '0;
        ev_ready_i = 1'b1;
        saw2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ev_src_o == 2'd2 || ack_o[2]) saw2 = 1'b1;
        end
        check("drop_never2", 32'(saw2), 32'd0);
        check("drop_empty",  32'(ev_valid_o), 32'd0);

        // Randomized traffic under the requester contract
        pulse_reset();
        for (int i = 0; i < 2000; i++) begin
            drive_random();
            step();
        end
        req_i = '0;
        ev_ready_i = 1'b1;
        step();
        step();
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
